// File: rtl/hamming_8_4_encoder.sv
// Splits each accepted byte into two SECDED (8,4) codewords, low nibble first, with optional error injection.
// Latency 1 cycle accept->low codeword; outputs hold under backpressure, and a new byte is taken on the high-codeword handshake.
module hamming_8_4_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic [7:0]  in_inj,
    input  logic        in_inj_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_code,
    output logic        out_last,
    input  logic        cnt_clr,
    output logic [15:0] cw_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] hi_q;
    logic [7:0] inj_q;
    logic       sel_q;

    logic       accept;
    logic [7:0] lo_code;
    logic [7:0] hi_code;

    // Parity bits sit at the power-of-two positions, so the syndrome is the XOR of set-bit indices.
    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0] c;
        c    = 8'h00;
        c[3] = d[0];
        c[5] = d[1];
        c[6] = d[2];
        c[7] = d[3];
        c[1] = d[0] ^ d[1] ^ d[3];
        c[2] = d[0] ^ d[2] ^ d[3];
        c[4] = d[1] ^ d[2] ^ d[3];
        c[0] = ^c[7:1];
        return c;
    endfunction

    assign in_ready = (state == IDLE) || ((state == SEND_HI) && out_ready);
    assign accept   = in_valid && in_ready;
    assign lo_code  = enc(in_data[3:0]) ^ (in_inj_sel ? 8'h00 : in_inj);
    assign hi_code  = enc(hi_q) ^ (sel_q ? inj_q : 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hi_q      <= 4'h0;
            inj_q     <= 8'h00;
            sel_q     <= 1'b0;
            out_valid <= 1'b0;
            out_code  <= 8'h00;
            out_last  <= 1'b0;
        end else if (accept) begin
            // Low codeword is encoded straight from the input; only the high nibble needs keeping.
            hi_q      <= in_data[7:4];
            inj_q     <= in_inj;
            sel_q     <= in_inj_sel;
            out_code  <= lo_code;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            state     <= SEND_LO;
        end else begin
            case (state)
                SEND_LO: begin
                    if (out_ready) begin
                        out_code <= hi_code;
                        out_last <= 1'b1;
                        state    <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_count <= 16'h0000;
        end else if (cnt_clr) begin
            cw_count <= 16'h0000;
        end else if (out_valid && out_ready && (cw_count != 16'hFFFF)) begin
            cw_count <= cw_count + 16'h0001;
        end
    end

endmodule

// File: doc/hamming_8_4_encoder.md
HAMMING_8_4_ENCODER -- requirements
Module: hamming_8_4_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: in_data and in_inj are valid this cycle.
REQ-004 SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-005 SHALL have port in_data, input, 8 bits: payload byte; [3:0] is the low nibble, [7:4] is the high nibble.
REQ-006 SHALL have port in_inj, input, 8 bits: error-injection mask captured with the byte.
REQ-007 SHALL have port in_inj_sel, input, 1 bit: injection target, 0 = low codeword, 1 = high codeword.
REQ-008 SHALL have port out_valid, output, 1 bit: out_code is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream decoder/sink accepts out_code.
REQ-010 SHALL have port out_code, output, 8 bits: SECDED (8,4) codeword.
REQ-011 SHALL have port out_last, output, 1 bit: out_code carries the high nibble.
REQ-012 SHALL have port cnt_clr, input, 1 bit: synchronous clear of cw_count.
REQ-013 SHALL have port cw_count, output, 16 bits: number of codewords delivered, saturating.

Function
REQ-014 SHALL use this codeword layout for nibble d: bit3=d0, bit5=d1, bit6=d2, bit7=d3; bit1=d0^d1^d3; bit2=d0^d2^d3; bit4=d1^d2^d3; bit0=XOR of bits 7..1 (even overall parity).
REQ-015 SHALL guarantee that an uninjected codeword has zero XOR-of-set-bit-index syndrome and even overall parity.
REQ-016 SHALL implement FSM states IDLE, SEND_LO and SEND_HI.
REQ-017 SHALL drive in_ready = (state==IDLE) | (state==SEND_HI & out_ready).
REQ-018 SHALL, on accept (in_valid & in_ready), register in_data, in_inj and in_inj_sel, then enter SEND_LO the next cycle.
REQ-019 SHALL drive out_valid=1 exactly in SEND_LO and SEND_HI; out_code and out_last are registered and come from flops.
REQ-020 SHALL give a latency of 1 cycle from accept to the low codeword on out_code.
REQ-021 SHALL move SEND_LO -> SEND_HI on out_valid & out_ready, presenting the high codeword the next cycle with out_last=1.
REQ-022 SHALL, in SEND_HI with out_ready: move to SEND_LO if in_valid, accepting the new byte with no bubble; otherwise move to IDLE.
REQ-023 SHALL hold out_code, out_last and out_valid stable while out_valid & !out_ready (backpressure).
REQ-024 SHALL apply the injection: out_code = encoded ^ in_inj for the selected codeword only; the other codeword is unmodified.
REQ-025 SHALL treat in_inj=0x00 as no injection.
REQ-026 SHALL increment cw_count by 1 per out_valid & out_ready, saturating at 0xFFFF.
REQ-027 SHALL give cnt_clr priority over increment on the same cycle, so cw_count becomes 0.
REQ-028 SHALL ignore in_valid while in_ready=0; in_data need not be held by the block.

Reset
REQ-029 SHALL, while rst=1, set state=IDLE, out_valid=0, out_code=0x00, out_last=0, cw_count=0 and all captured registers to 0.
REQ-030 SHALL, on rst asserted mid-transfer (SEND_LO or SEND_HI), discard the byte in flight and emit no partial pair after release.
REQ-031 SHALL drive in_ready=1 from the first cycle after rst deasserts.

Verification
REQ-032 SHALL cover: byte 0xA1 with out_ready=1 and inj=0 -> out_code 0x0F (out_last=0), then 0xA5 (out_last=1) on consecutive cycles; cw_count=2.
REQ-033 SHALL cover: bytes 0x00 then 0xFF back-to-back with out_ready=1 -> 0x00, 0x00, 0xFF, 0xFF with no idle cycle between pairs.
REQ-034 SHALL cover: byte 0xA1 with out_ready held 0 for 5 cycles -> out_code stays 0x0F with out_valid=1; in_ready=0 throughout.
REQ-035 SHALL cover: byte 0xA1, in_inj=0x08, in_inj_sel=1 -> outputs 0x0F then 0xAD; a downstream SECDED decoder flags a single error at bit 3 and corrects it to 0xA5.
REQ-036 SHALL cover: rst pulsed while in SEND_HI -> out_valid=0 and cw_count=0 next cycle, in_ready=1 after release.
REQ-037 SHALL cover: cw_count preloaded by traffic to 0xFFFF plus one more delivered codeword -> stays 0xFFFF; cnt_clr together with a handshake -> 0.
